// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: default data width, output-gate states and
// pointer sizing used by the packet FIFO and its RAM.
package axis_pkg;

    localparam int AXIS_DATA_W = 8;

    typedef enum logic [1:0] {
        GATE_WAIT,
        GATE_SEND,
        GATE_FORCE
    } gate_state_t;

    // One extra bit above the address lets full and empty be told apart
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream beat bundle; the producer side takes the master modport and the
// consumer side takes the slave modport.
interface axis_pkt_fifo_if
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: synchronous write, asynchronous read.
module axis_fifo_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             axis_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge axis_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO with occupancy and packet counters. Defining
// AXIS_PKT_FIFO_STORE_FWD_EN holds output until a whole packet is buffered.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                    axis_clk,
    input  logic                    resetn,
    axis_pkt_fifo_if.slave          s_axis,
    axis_pkt_fifo_if.master         m_axis,
    output logic [ptr_w(DEPTH)-1:0] occupancy,
    output logic [ptr_w(DEPTH)-1:0] pkt_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [PW-1:0] occupancy_nxt, pkt_count_nxt;
    logic          s_ready_q, empty, full_nxt;
    logic          wr_en, rd_en, wr_last, rd_last, m_valid;
    logic [DATA_W:0] rd_word;

    axis_fifo_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .axis_clk (axis_clk),
        .we       (wr_en),
        .waddr    (wr_ptr[AW-1:0]),
        .wdata    ({s_axis.tlast, s_axis.tdata}),
        .raddr    (rd_ptr[AW-1:0]),
        .rdata    (rd_word)
    );

    assign empty      = (wr_ptr == rd_ptr);
    assign wr_en      = s_axis.tvalid && s_ready_q;
    assign rd_en      = m_valid && m_axis.tready;
    assign wr_last    = wr_en && s_axis.tlast;
    assign rd_last    = rd_en && rd_word[DATA_W];
    assign wr_ptr_nxt = wr_ptr + PW'(wr_en);
    assign rd_ptr_nxt = rd_ptr + PW'(rd_en);
    assign full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                        (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_valid ? rd_word[DATA_W-1:0] : '0;
    assign m_axis.tlast  = m_valid && rd_word[DATA_W];

    // Counters move only when exactly one side of the FIFO transfers
    always_comb begin
        occupancy_nxt = occupancy;
        pkt_count_nxt = pkt_count;
        case ({wr_en, rd_en})
            2'b10:   occupancy_nxt = occupancy + PW'(1);
            2'b01:   occupancy_nxt = occupancy - PW'(1);
            default: occupancy_nxt = occupancy;
        endcase
        case ({wr_last, rd_last})
            2'b10:   pkt_count_nxt = pkt_count + PW'(1);
            2'b01:   pkt_count_nxt = pkt_count - PW'(1);
            default: pkt_count_nxt = pkt_count;
        endcase
    end

    // Ready is registered from next-cycle fullness, so it never follows the sink
    always_ff @(posedge axis_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            s_ready_q <= 1'b0;
            occupancy <= '0;
            pkt_count <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            s_ready_q <= !full_nxt;
            occupancy <= occupancy_nxt;
            pkt_count <= pkt_count_nxt;
        end
    end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    gate_state_t state, state_nxt;
    logic        full;

    assign full = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge axis_clk or negedge resetn) begin
        if (!resetn) begin
            state <= GATE_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT may present a beat as soon as a complete packet is counted
    always_comb begin
        m_valid = 1'b0;
        case (state)
            GATE_WAIT:  m_valid = (pkt_count != '0) && !empty;
            GATE_SEND:  m_valid = !empty;
            GATE_FORCE: m_valid = !empty;
            default:    m_valid = 1'b0;
        endcase
    end

    // FORCE drains a packet longer than the FIFO so the writer cannot stall forever
    always_comb begin
        state_nxt = state;
        case (state)
            GATE_WAIT: begin
                if (pkt_count != '0) begin
                    if (!(rd_last && pkt_count_nxt == '0)) begin
                        state_nxt = GATE_SEND;
                    end
                end else if (full) begin
                    state_nxt = GATE_FORCE;
                end
            end
            GATE_SEND: begin
                if (rd_last && pkt_count_nxt == '0) begin
                    state_nxt = GATE_WAIT;
                end
            end
            GATE_FORCE: begin
                if (rd_last) begin
                    state_nxt = GATE_WAIT;
                end
            end
            default: state_nxt = GATE_WAIT;
        endcase
    end
`else
    assign m_valid = !empty;
`endif

endmodule
